ddr2_data_tap_seq: RTL and testbench



---
 rtl/ddr2_tap_seq_pkg.sv | 18 +
 rtl/ddr2_tap_counter.sv | 19 +
 rtl/ddr2_data_tap_seq.sv | 85 ++++++++
 tb/tb_ddr2_data_tap_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_tap_seq_pkg.sv
// ddr2_tap_seq_pkg: state encoding and channel-search helpers for the per-bit tap sequencer
package ddr2_tap_seq_pkg;
  typedef enum logic [1:0] {IDLE, CAL, DONE, ERR} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // lowest unmasked channel strictly above cur, or -1 when the walk is exhausted
  function automatic int next_unmasked(input logic [15:0] mask, input int cur, input int bits);
    int r;
    r = -1;
    for (int i = 15; i >= 0; i--)
      if (i > cur && i < bits && !mask[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/ddr2_tap_counter.sv
// ddr2_tap_counter: saturating up/down IDELAY tap counter with range-violation flag
module ddr2_tap_counter #(
  parameter int TAP_W    = 6,
  parameter int MAX_TAPS = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic             inc,
  output logic [TAP_W-1:0] count,
  output logic             viol
);
  assign viol = step && (inc ? count == TAP_W'(MAX_TAPS) : count == '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (step && !viol) count <= inc ? count + 1'b1 : count - 1'b1;
endmodule

// File: rtl/ddr2_data_tap_seq.sv
// ddr2_data_tap_seq: walks unmasked DQ channels, routes IDELAY steps, tracks taps and captures skew
module ddr2_data_tap_seq import ddr2_tap_seq_pkg::*; #(
  parameter int DQ_BITS  = 8,
  parameter int TAP_W    = 6,
  parameter int MAX_TAPS = 63,
  parameter int IDX_W    = clog2(DQ_BITS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DQ_BITS-1:0] calibration_dq,
  input  logic               ctrl_calib_start,
  input  logic               dlyinc,
  input  logic               dlyce,
  input  logic               chan_done,
  input  logic [DQ_BITS-1:0] chan_mask,
  input  logic               recal,
  input  logic [IDX_W-1:0]   tap_rd_sel,
  output logic               dq_data,
  output logic [IDX_W-1:0]   chan_idx,
  output logic [DQ_BITS-1:0] data_dlyinc,
  output logic [DQ_BITS-1:0] data_dlyce,
  output logic [DQ_BITS-1:0] data_dlyrst,
  output logic               calib_done,
  output logic               calib_err,
  output logic [DQ_BITS-1:0] per_bit_skew,
  output logic [TAP_W-1:0]   tap_rd
);
  state_t state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [DQ_BITS-1:0] mask_r, mask_n, cal_dq_r, step_v, viol_v;
  logic [TAP_W-1:0] counts [DQ_BITS];
  logic cmd;
  int nu;
  assign cmd = state == CAL && ctrl_calib_start && !recal;
  assign data_dlyce = step_v & ~viol_v;
  assign dq_data = cal_dq_r[chan_idx];
  assign calib_done = state == DONE;
  assign calib_err = state == ERR;
  assign tap_rd = counts[tap_rd_sel];
  for (genvar i = 0; i < DQ_BITS; i++) begin : g_ch
    assign step_v[i] = cmd && dlyce && chan_idx == IDX_W'(i);
    assign data_dlyinc[i] = cmd && dlyinc && chan_idx == IDX_W'(i);
    ddr2_tap_counter #(.TAP_W(TAP_W), .MAX_TAPS(MAX_TAPS)) u_cnt (
      .clk, .reset, .clr(recal), .step(step_v[i]), .inc(dlyinc),
      .count(counts[i]), .viol(viol_v[i])
    );
  end
  always_comb begin
    state_n = state;
    idx_n = chan_idx;
    mask_n = mask_r;
    nu = -1;
    if (recal) begin
      state_n = IDLE;
      idx_n = '0;
    end else if (state == IDLE && ctrl_calib_start) begin
      mask_n = chan_mask;
      nu = next_unmasked(16'(chan_mask), -1, DQ_BITS);
      state_n = nu < 0 ? DONE : CAL;
      idx_n = nu < 0 ? chan_idx : IDX_W'(nu);
    end else if (state == CAL && ctrl_calib_start) begin
      // an out-of-range step wins over a same-cycle chan_done
      nu = next_unmasked(16'(mask_r), int'(chan_idx), DQ_BITS);
      state_n = |viol_v ? ERR : (chan_done && nu < 0) ? DONE : CAL;
      idx_n = (!(|viol_v) && chan_done && nu >= 0) ? IDX_W'(nu) : chan_idx;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      chan_idx <= '0;
      mask_r <= '0;
      cal_dq_r <= '0;
      per_bit_skew <= '0;
      data_dlyrst <= '1;
    end else begin
      state <= state_n;
      chan_idx <= idx_n;
      mask_r <= mask_n;
      cal_dq_r <= calibration_dq;
      data_dlyrst <= {DQ_BITS{recal}};
      if (recal) per_bit_skew <= '0;
      else if (state_n == DONE && state != DONE) per_bit_skew <= cal_dq_r & ~mask_n;
    end
endmodule

// File: tb/tb_ddr2_data_tap_seq.sv
// tb_ddr2_data_tap_seq: vector table plus directed sequences for the per-bit tap sequencer
module tb_ddr2_data_tap_seq;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] calibration_dq, chan_mask;
  logic ctrl_calib_start, dlyinc, dlyce, chan_done, recal;
  logic [2:0] tap_rd_sel;
  logic dq_data, calib_done, calib_err;
  logic [2:0] chan_idx;
  logic [7:0] data_dlyinc, data_dlyce, data_dlyrst, per_bit_skew;
  logic [5:0] tap_rd;

  ddr2_data_tap_seq dut (
    .clk(clk), .reset(reset), .calibration_dq(calibration_dq), .ctrl_calib_start(ctrl_calib_start),
    .dlyinc(dlyinc), .dlyce(dlyce), .chan_done(chan_done), .chan_mask(chan_mask), .recal(recal),
    .tap_rd_sel(tap_rd_sel), .dq_data(dq_data), .chan_idx(chan_idx), .data_dlyinc(data_dlyinc),
    .data_dlyce(data_dlyce), .data_dlyrst(data_dlyrst), .calib_done(calib_done),
    .calib_err(calib_err), .per_bit_skew(per_bit_skew), .tap_rd(tap_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ce, inc, done;
    logic [2:0] sel;
    logic [7:0] e_ce, e_inc;
    logic [2:0] e_idx;
    logic [5:0] e_tap;
    logic e_done;
  } vec_t;

  vec_t vt[11];
  logic exp_q[$];
  logic [7:0] dq_pat[6];
  logic [2:0] walk[4];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ctrl_calib_start = 1'b0;
    dlyce = 1'b0;
    dlyinc = 1'b0;
    chan_done = 1'b0;
    recal = 1'b0;
  endtask

  task automatic do_recal();
    quiet();
    recal = 1'b1;
    cyc();
    recal = 1'b0;
    @(negedge clk);
    chk("recal_dlyrst_on", data_dlyrst, 8'hFF);
    chk("recal_done", calib_done, 1'b0);
    chk("recal_err", calib_err, 1'b0);
    chk("recal_skew", per_bit_skew, 8'h00);
    chk("recal_tap", tap_rd, 6'd0);
    cyc();
    @(negedge clk);
    chk("recal_dlyrst_off", data_dlyrst, 8'h00);
    cyc();
  endtask

  function automatic vec_t mk(input logic ce, input logic inc, input logic done, input logic [2:0] sel,
                              input logic [7:0] e_ce, input logic [7:0] e_inc, input logic [2:0] e_idx,
                              input logic [5:0] e_tap, input logic e_done);
    vec_t v;
    v.ce = ce; v.inc = inc; v.done = done; v.sel = sel;
    v.e_ce = e_ce; v.e_inc = e_inc; v.e_idx = e_idx; v.e_tap = e_tap; v.e_done = e_done;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 8'h01, 3'd0, 6'd0, 1'b0);
    vt[1]  = mk(1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 3'd0, 6'd1, 1'b0);
    vt[2]  = mk(1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 8'h02, 3'd1, 6'd0, 1'b0);
    vt[3]  = mk(1'b1, 1'b1, 1'b1, 3'd0, 8'h02, 8'h02, 3'd1, 6'd2, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 3'd2, 6'd1, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 3'd3, 6'd1, 1'b0);
    vt[6]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 3'd4, 6'd1, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 3'd5, 6'd1, 1'b0);
    vt[8]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 3'd6, 6'd1, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 3'd7, 6'd0, 1'b0);
    vt[10] = mk(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 3'd7, 6'd2, 1'b1);
    dq_pat = '{8'h01, 8'hFE, 8'hFF, 8'h00, 8'h81, 8'h10};
    walk = '{3'd1, 3'd3, 3'd4, 3'd6};

    reset = 1'b1;
    quiet();
    calibration_dq = 8'h00;
    chan_mask = 8'h00;
    tap_rd_sel = 3'd0;
    @(negedge clk);
    chk("rst_idx", chan_idx, 3'd0);
    chk("rst_done", calib_done, 1'b0);
    chk("rst_err", calib_err, 1'b0);
    chk("rst_skew", per_bit_skew, 8'h00);
    chk("rst_dlyrst", data_dlyrst, 8'hFF);
    chk("rst_dq", dq_data, 1'b0);
    chk("rst_tap", tap_rd, 6'd0);
    reset = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_dlyrst_clear", data_dlyrst, 8'h00);

    for (int i = 0; i < 6; i++) begin
      calibration_dq = dq_pat[i];
      exp_q.push_back(dq_pat[i][0]);
      cyc();
      @(negedge clk);
      chk($sformatf("dq_lat%0d", i), dq_data, exp_q.pop_front());
    end

    cyc();
    calibration_dq = 8'h5A;
    chan_mask = 8'h00;
    ctrl_calib_start = 1'b1;
    cyc();
    for (int i = 0; i < 11; i++) begin
      dlyce = vt[i].ce;
      dlyinc = vt[i].inc;
      chan_done = vt[i].done;
      tap_rd_sel = vt[i].sel;
      @(negedge clk);
      chk($sformatf("v%0d_ce", i), data_dlyce, vt[i].e_ce);
      chk($sformatf("v%0d_inc", i), data_dlyinc, vt[i].e_inc);
      chk($sformatf("v%0d_idx", i), chan_idx, vt[i].e_idx);
      chk($sformatf("v%0d_tap", i), tap_rd, vt[i].e_tap);
      chk($sformatf("v%0d_done", i), calib_done, vt[i].e_done);
      cyc();
    end
    chk("walk_skew", per_bit_skew, 8'h5A);

    do_recal();
    calibration_dq = 8'hFF;
    chan_mask = 8'hA5;
    ctrl_calib_start = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mask_idx%0d", k), chan_idx, walk[k]);
      cyc();
      chan_done = 1'b1;
      cyc();
      chan_done = 1'b0;
      @(negedge clk);
      chk($sformatf("mask_done%0d", k), calib_done, k == 3);
      cyc();
    end
    chk("mask_skew", per_bit_skew, 8'h5A);

    do_recal();
    chan_mask = 8'hFF;
    ctrl_calib_start = 1'b1;
    dlyce = 1'b1;
    dlyinc = 1'b1;
    @(negedge clk);
    chk("allmask_idle_ce", data_dlyce, 8'h00);
    cyc();
    @(negedge clk);
    chk("allmask_done", calib_done, 1'b1);
    chk("allmask_ce", data_dlyce, 8'h00);
    chk("allmask_skew", per_bit_skew, 8'h00);

    do_recal();
    chan_mask = 8'h00;
    ctrl_calib_start = 1'b1;
    cyc();
    chan_done = 1'b1;
    cyc();
    cyc();
    chan_done = 1'b0;
    tap_rd_sel = 3'd2;
    dlyce = 1'b1;
    dlyinc = 1'b1;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      chk($sformatf("sat_ce%0d", i), data_dlyce, 8'h04);
      cyc();
    end
    @(negedge clk);
    chk("sat_tap63", tap_rd, 6'd63);
    chk("sat_ce64", data_dlyce, 8'h00);
    chk("sat_err_pre", calib_err, 1'b0);
    cyc();
    @(negedge clk);
    chk("sat_err", calib_err, 1'b1);
    chk("sat_tap_hold", tap_rd, 6'd63);
    chk("sat_err_ce", data_dlyce, 8'h00);
    cyc();
    do_recal();

    ctrl_calib_start = 1'b1;
    tap_rd_sel = 3'd0;
    cyc();
    dlyce = 1'b1;
    dlyinc = 1'b0;
    @(negedge clk);
    chk("under_ce", data_dlyce, 8'h00);
    cyc();
    @(negedge clk);
    chk("under_err", calib_err, 1'b1);
    chk("under_tap", tap_rd, 6'd0);
    cyc();
    do_recal();

    ctrl_calib_start = 1'b1;
    cyc();
    dlyce = 1'b1;
    dlyinc = 1'b1;
    @(negedge clk);
    chk("hold_pre_ce", data_dlyce, 8'h01);
    cyc();
    ctrl_calib_start = 1'b0;
    chan_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ce%0d", i), data_dlyce, 8'h00);
      chk($sformatf("hold_inc%0d", i), data_dlyinc, 8'h00);
      chk($sformatf("hold_idx%0d", i), chan_idx, 3'd0);
      chk($sformatf("hold_tap%0d", i), tap_rd, 6'd1);
      cyc();
    end
    ctrl_calib_start = 1'b1;
    dlyce = 1'b0;
    cyc();
    chan_done = 1'b0;
    dlyce = 1'b1;
    @(negedge clk);
    chk("arst_pre_idx", chan_idx, 3'd1);
    chk("arst_pre_ce", data_dlyce, 8'h02);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_idx", chan_idx, 3'd0);
    chk("arst_ce", data_dlyce, 8'h00);
    chk("arst_inc", data_dlyinc, 8'h00);
    chk("arst_dlyrst", data_dlyrst, 8'hFF);
    chk("arst_dq", dq_data, 1'b0);
    chk("arst_tap", tap_rd, 6'd0);
    cyc();
    quiet();
    reset = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
